// File: rtl/key_dispatch.sv
// key_dispatch: PS/2 make-code decoder with repeat filter, move router into per-player FIFOs, system command pulses.
// Latency: key_event -> pN_move 2 cycles (rdy high at the next edge); key_event -> sys_cmd 1 cycle.
// Backpressure: pN_rdy low parks moves in a DEPTH-entry FIFO; a move hitting a full FIFO is dropped and counted.
// Build option: define KEY_DISPATCH_SWAP_EN to build the timed control-swap window; otherwise routing is always direct.

// Small synchronous FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
module key_dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           dat_i,
   output logic [W-1:0]           dat_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dat_o   = mem_q[rd_q];
   assign level_o = cnt_q;

   // Pointer and occupancy next state; a flush overrides any push or pop.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_ONE;
         if (do_pop)  rd_d = rd_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; occupancy gates every read, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= dat_i;
   end
endmodule

module key_dispatch #(
   parameter int DEPTH       = 4,
   parameter int SWAP_CYCLES = 10
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [10:0]            key_event,
   input  logic                   enable,
   input  logic                   swap_req,
   input  logic                   p1_rdy,
   input  logic                   p2_rdy,
   output logic [3:0]             p1_move,
   output logic [3:0]             p2_move,
   output logic [2:0]             sys_cmd,
   output logic                   swapped,
   output logic [$clog2(DEPTH):0] p1_level,
   output logic [$clog2(DEPTH):0] p2_level,
   output logic [7:0]             drop_cnt
);
   // Move encoding stored in the FIFOs.
   localparam logic [1:0] MV_UP = 2'd0, MV_DOWN = 2'd1, MV_LEFT = 2'd2, MV_RIGHT = 2'd3;

   logic        kv, ke0, kbrk;
   logic [7:0]  kcode;
   logic [8:0]  code9;
   logic [8:0]  last_q, last_d;
   logic        accept;
   logic        mv_vld, mv_src;
   logic [1:0]  mv_dir;
   logic [2:0]  sys_q, sys_d;
   logic        swap_act, to_p2;
   logic        push1, push2, pop1, pop2;
   logic        full1, full2, empty1, empty2;
   logic [1:0]  head1, head2;
   logic [3:0]  p1_move_q, p1_move_d, p2_move_q, p2_move_d;
   logic [7:0]  drop_q, drop_d;
   logic        drop;

   // Map a stored move to the one-hot {up,down,left,right} pulse.
   function automatic logic [3:0] dir2oh(input logic [1:0] d);
      return 4'b1000 >> d;
   endfunction

   assign kv    = key_event[10];
   assign ke0   = key_event[9];
   assign kbrk  = key_event[8];
   assign kcode = key_event[7:0];
   assign code9 = {ke0, kcode};

   // Repeat filter and key decode: only a make that differs from the last accepted code acts.
   always_comb begin
      accept = kv & ~kbrk & (code9 != last_q);
      last_d = last_q;
      mv_vld = 1'b0;
      mv_src = 1'b0;
      mv_dir = MV_UP;
      sys_d  = 3'b000;
      if (accept) begin
         last_d = code9;
      end else if (kv && kbrk && (code9 == last_q)) begin
         last_d = 9'd0;
      end
      if (accept) begin
         case (code9)
            9'h01D:  begin mv_vld = 1'b1; mv_src = 1'b0; mv_dir = MV_UP;    end
            9'h01B:  begin mv_vld = 1'b1; mv_src = 1'b0; mv_dir = MV_DOWN;  end
            9'h01C:  begin mv_vld = 1'b1; mv_src = 1'b0; mv_dir = MV_LEFT;  end
            9'h023:  begin mv_vld = 1'b1; mv_src = 1'b0; mv_dir = MV_RIGHT; end
            9'h175:  begin mv_vld = 1'b1; mv_src = 1'b1; mv_dir = MV_UP;    end
            9'h172:  begin mv_vld = 1'b1; mv_src = 1'b1; mv_dir = MV_DOWN;  end
            9'h16B:  begin mv_vld = 1'b1; mv_src = 1'b1; mv_dir = MV_LEFT;  end
            9'h174:  begin mv_vld = 1'b1; mv_src = 1'b1; mv_dir = MV_RIGHT; end
            default: mv_vld = 1'b0;
         endcase
         // System keys are recognised by scan code alone and ignore enable.
         case (kcode)
            8'h29:   sys_d = 3'b100;
            8'h4D:   sys_d = 3'b010;
            8'h2D:   sys_d = 3'b001;
            default: sys_d = 3'b000;
         endcase
      end
   end

`ifdef KEY_DISPATCH_SWAP_EN
   localparam logic [7:0] SWAP_LD = 8'(SWAP_CYCLES);
   logic [7:0] swap_q, swap_d;

   // Swap window: a request (re)loads the full length, otherwise count down to zero.
   always_comb begin
      swap_d = swap_q;
      if (swap_req)             swap_d = SWAP_LD;
      else if (swap_q != 8'd0)  swap_d = swap_q - 8'd1;
   end

   // Swap window counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) swap_q <= 8'd0;
      else       swap_q <= swap_d;
   end

   assign swap_act = (swap_q != 8'd0);
`else
   localparam int unused_swap_cycles = SWAP_CYCLES;
   logic unused_swap_req;
   assign unused_swap_req = swap_req;
   assign swap_act        = 1'b0;
`endif

   // Routing uses the window state registered before this edge, so a same-edge request does not affect it.
   assign to_p2 = mv_src ^ swap_act;
   assign push1 = enable & mv_vld & ~to_p2;
   assign push2 = enable & mv_vld & to_p2;
   assign pop1  = enable & p1_rdy & ~empty1;
   assign pop2  = enable & p2_rdy & ~empty2;
   assign drop  = (push1 & full1 & ~pop1) | (push2 & full2 & ~pop2);

   key_dispatch_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo1 (
      .clk(clk), .rstn(rstn), .flush_i(~enable), .push_i(push1), .pop_i(pop1),
      .dat_i(mv_dir), .dat_o(head1), .level_o(p1_level), .full_o(full1), .empty_o(empty1)
   );

   key_dispatch_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo2 (
      .clk(clk), .rstn(rstn), .flush_i(~enable), .push_i(push2), .pop_i(pop2),
      .dat_i(mv_dir), .dat_o(head2), .level_o(p2_level), .full_o(full2), .empty_o(empty2)
   );

   // Next-state of the issue pulses and the saturating drop counter.
   always_comb begin
      p1_move_d = pop1 ? dir2oh(head1) : 4'd0;
      p2_move_d = pop2 ? dir2oh(head2) : 4'd0;
      drop_d    = drop_q;
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // Output and filter state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_q    <= 9'd0;
         sys_q     <= 3'b000;
         p1_move_q <= 4'd0;
         p2_move_q <= 4'd0;
         drop_q    <= 8'd0;
      end else begin
         last_q    <= last_d;
         sys_q     <= sys_d;
         p1_move_q <= p1_move_d;
         p2_move_q <= p2_move_d;
         drop_q    <= drop_d;
      end
   end

   assign p1_move  = p1_move_q;
   assign p2_move  = p2_move_q;
   assign sys_cmd  = sys_q;
   assign swapped  = swap_act;
   assign drop_cnt = drop_q;
endmodule
